// File: rtl/gcm_pkg.sv
// rtl/gcm_pkg.sv - GF(2^128) types, reduction constant and multiply-by-x helpers
package gcm_pkg;

  typedef logic [127:0] gf128_t;

  // Reflected reduction constant for P = x^128 + x^7 + x^2 + x + 1.
  // Bit 127 is the x^0 coefficient, so multiplying by x is a right shift.
  localparam gf128_t GCM_R = 128'hE1 << 120;

  // Multiply by x once: shift toward higher powers, fold x^128 back in.
  function automatic gf128_t gf128_mulx(input gf128_t v);
    return v[0] ? ((v >> 1) ^ GCM_R) : (v >> 1);
  endfunction

  // Multiply by x^n. n is a constant at every call site, so this unrolls
  // into a fixed XOR network.
  function automatic gf128_t gf128_mulx_n(input gf128_t v, input int n);
    gf128_t r;
    r = v;
    for (int i = 0; i < 128; i++) begin
      if (i < n) r = gf128_mulx(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf128_slice_mul.sv
// rtl/gf128_slice_mul.sv - combinational op * slice * x^(32K) mod P
module gf128_slice_mul
  import gcm_pkg::*;
#(
  parameter int K = 0
) (
  input  gf128_t      op_i,
  input  logic [31:0] slice_i,
  output gf128_t      prod_o
);

  // Slice bit 31 is the lowest power in this slice (x^(32K)); walk the
  // slice from there, shifting the operand by x between taps.
  always_comb begin : shift_and_reduce
    gf128_t tap_v;
    gf128_t sum_v;
    tap_v = gf128_mulx_n(op_i, 32 * K);
    sum_v = '0;
    for (int j = 0; j < 32; j++) begin
      if (slice_i[31-j]) sum_v = sum_v ^ tap_v;
      tap_v = gf128_mulx(tap_v);
    end
    prod_o = sum_v;
  end

endmodule

// File: rtl/split_multiplier.sv
// rtl/split_multiplier.sv - GHASH multiplier with sliced H and accumulating result
module split_multiplier
  import gcm_pkg::*;
#(
  parameter int DATA__WIDTH = 128,
  parameter int SPLIT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [SPLIT_WIDTH-1:0] ha_i,
  input  logic [SPLIT_WIDTH-1:0] hb_i,
  input  logic [SPLIT_WIDTH-1:0] hc_i,
  input  logic [SPLIT_WIDTH-1:0] hd_i,
  input  logic [DATA__WIDTH-1:0] a_i,
  output logic [DATA__WIDTH-1:0] mul_o
);

  localparam int NSLICE = DATA__WIDTH / SPLIT_WIDTH;

  gf128_t                 op_q, op_d;
  gf128_t                 acc_q, acc_d;
  logic [DATA__WIDTH-1:0] hw;
  gf128_t                 part [NSLICE];

  // New operand bits fold into the held operand; the product of this
  // cycle's slices uses the updated operand.
  always_comb begin
    op_d = a_i ^ op_q;
    hw   = {ha_i, hb_i, hc_i, hd_i};
  end

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    gf128_slice_mul #(
      .K(k)
    ) u_slice (
      .op_i   (op_d),
      .slice_i(hw[DATA__WIDTH-1-SPLIT_WIDTH*k -: SPLIT_WIDTH]),
      .prod_o (part[k])
    );
  end

  // Linear in H: absent slices contribute zero, so partial products
  // simply XOR into the running sum.
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < NSLICE; k++) begin
      acc_d = acc_d ^ part[k];
    end
  end

  // Operand and accumulator registers; flush behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      op_q  <= '0;
      acc_q <= '0;
    end else begin
      op_q  <= op_d;
      acc_q <= acc_d;
    end
  end

  assign mul_o = acc_q;

endmodule

// File: tb/tb_split_multiplier.sv
// tb/tb_split_multiplier.sv - self-checking bench for split_multiplier
module tb_split_multiplier;

  localparam logic [127:0] R_CONST = 128'hE1 << 120;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [31:0]  ha = '0, hb = '0, hc = '0, hd = '0;
  logic [127:0] a = '0;
  logic [127:0] mul;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] m_op = '0;
  logic [127:0] m_acc = '0;

  split_multiplier dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .ha_i (ha),
    .hb_i (hb),
    .hc_i (hc),
    .hd_i (hd),
    .a_i  (a),
    .mul_o(mul)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Textbook GCM multiply: walk X from the x^0 coefficient, shifting V by x.
  function automatic logic [127:0] gfmul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ R_CONST) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] slice_of(input logic [127:0] h, input int k);
    logic [127:0] m;
    m = {32'hFFFF_FFFF, 96'h0} >> (32 * k);
    return h & m;
  endfunction

  task automatic drive(input logic r, input logic f, input logic [127:0] av,
                       input logic [127:0] hv);
    rst   = r;
    flush = f;
    a     = av;
    {ha, hb, hc, hd} = hv;
    @(posedge clk);
    #1;
    if (r || f) begin
      m_op  = '0;
      m_acc = '0;
    end else begin
      m_op  = m_op ^ av;
      m_acc = m_acc ^ gfmul(m_op, hv);
    end
  endtask

  task automatic check(input string tag, input logic [127:0] exp);
    n_cmp++;
    assert (mul === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, mul, exp);
    end
  endtask

  task automatic run_vec(input logic [127:0] h, input logic [127:0] av);
    drive(1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b0, av, slice_of(h, 0));
    drive(1'b0, 1'b0, '0, slice_of(h, 1));
    drive(1'b0, 1'b0, '0, slice_of(h, 2));
    drive(1'b0, 1'b0, '0, slice_of(h, 3));
  endtask

  localparam logic [127:0] H1 = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] A1 = 128'h42831ec2217774244b7221b784d0d49c;
  localparam logic [127:0] H2 = 128'h8a6ff5aca561c0d865805055eb728397;
  localparam logic [127:0] H3 = 128'hc414cb8f1152eb71563a5ca9ddcbddb5;
  localparam logic [127:0] H4 = 128'h3c4b0daa91e6b35f9b9e89d8510dd431;
  localparam logic [127:0] H5 = 128'h423dbfb8033039e6b9cb105cf1d6f3b1;

  initial begin
    logic [127:0] ha_v, av_v;
    int perm [4];

    // reset held 4 cycles
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, rand128(), rand128());
      check("reset", '0);
    end

    // known-answer vectors
    run_vec(H1, A1);
    check("vec1", 128'h59ed3f2bb1a0aaa07c9f56c6a504647b);
    drive(1'b0, 1'b1, '0, '0);
    check("flush_after_vec1", '0);
    run_vec(H1, H1);
    check("vec2_h2", H2);
    run_vec(H2, H1);
    check("vec3_h3", H3);
    run_vec(H2, H2);
    check("vec4_h4", H4);
    run_vec(H2, H3);
    check("vec5_h5", H5);

    // hold: zero slices keep the result, first with a_i=0 then random a_i
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, (i < 10) ? 128'h0 : rand128(), '0);
      check("hold", H5);
    end

    // abort mid-operation: reset after two slices discards the partial sum
    drive(1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b0, A1, slice_of(H1, 0));
    drive(1'b0, 1'b0, '0, slice_of(H1, 1));
    drive(1'b1, 1'b0, '0, slice_of(H1, 2));
    check("abort_reset", '0);
    drive(1'b0, 1'b0, '0, slice_of(H1, 2));
    drive(1'b0, 1'b0, '0, slice_of(H1, 3));
    check("abort_discard", '0);

    // random products with slices in random order, and all at once
    for (int t = 0; t < 24; t++) begin
      ha_v = rand128();
      av_v = rand128();
      for (int k = 0; k < 4; k++) perm[k] = k;
      for (int k = 3; k > 0; k--) begin
        int j, tmp;
        j = int'($urandom_range(k, 0));
        tmp = perm[k];
        perm[k] = perm[j];
        perm[j] = tmp;
      end
      drive(1'b0, 1'b1, '0, '0);
      if (t % 4 == 3) begin
        drive(1'b0, 1'b0, av_v, ha_v);
      end else begin
        for (int k = 0; k < 4; k++) begin
          drive(1'b0, 1'b0, (k == 0) ? av_v : 128'h0, slice_of(ha_v, perm[k]));
        end
      end
      check("rand_product", gfmul(av_v, ha_v));
    end

    // free-running random traffic against the accumulating model
    for (int t = 0; t < 300; t++) begin
      logic [127:0] hv;
      hv = '0;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(1, 0) == 1) hv = hv | slice_of(rand128(), k);
      end
      drive(($urandom_range(39, 0) == 0), ($urandom_range(15, 0) == 0),
            ($urandom_range(2, 0) == 0) ? rand128() : 128'h0, hv);
      check("rand_stream", m_acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
